// File: rtl/omsp_spm_key_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : omsp_spm_key_writer_pkg
// Description : Shared definitions for the SM key writer: key width default,
//               key-word geometry, FSM state encoding and the word-count
//               helper used to size the index counter.
// Revision    : 1.0 - initial release
// ============================================================================
package omsp_spm_key_writer_pkg;

    // Default module-key width used throughout the SPM logic.
    localparam int unsigned SPM_SECURITY   = 64;

    // Key words travel 16 bits at a time from the derivation engine.
    localparam int unsigned SPM_WORD_W     = 16;

    // Width of the idle-cycle counter guarding the word stream.
    localparam int unsigned SPM_TO_CNT_W   = 8;

    typedef enum logic [1:0] {
        KW_IDLE    = 2'd0,
        KW_COLLECT = 2'd1,
        KW_FLUSH   = 2'd2
    } kw_state_e;

    // Number of 16-bit words making up one key.
    function automatic int unsigned spm_nw(input int unsigned security);
        return security / SPM_WORD_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/omsp_spm_key_writer_timeout.sv
`default_nettype none
// ============================================================================
// Module      : omsp_spm_key_writer_timeout
// Description : Saturating idle-cycle counter. Cleared (loaded with zero) on
//               clear_i, advanced on inc_i. expire_o flags that the next idle
//               tick brings the count to TIMEOUT, so the owner can terminate
//               the transfer on that same edge. TIMEOUT=0 disables expiry.
// Ports       : mclk, puc_rst   - clock, async active-high reset
//               clear_i         - reload count with zero (wins over inc_i)
//               inc_i           - count one idle cycle
//               enable_o        - timeout supervision is active
//               expire_o        - next idle tick reaches TIMEOUT
// Revision    : 1.0 - initial release
// ============================================================================
module omsp_spm_key_writer_timeout
    import omsp_spm_key_writer_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic mclk,
    input  logic puc_rst,
    input  logic clear_i,
    input  logic inc_i,
    output logic enable_o,
    output logic expire_o
);

    localparam logic [SPM_TO_CNT_W-1:0] C_LIMIT_M1 = SPM_TO_CNT_W'(TIMEOUT - 1);
    localparam logic [SPM_TO_CNT_W-1:0] C_SAT      = '1;
    localparam logic                    C_ENABLE   = (TIMEOUT != 0) ? 1'b1 : 1'b0;

    logic [SPM_TO_CNT_W-1:0] cnt_q;
    logic [SPM_TO_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != C_SAT)) begin
            cnt_d = cnt_q + SPM_TO_CNT_W'(1);
        end
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign enable_o = C_ENABLE;
    assign expire_o = C_ENABLE & (cnt_q == C_LIMIT_M1);

endmodule
`default_nettype wire

// File: rtl/omsp_spm_key_writer.sv
`default_nettype none
// ============================================================================
// Module      : omsp_spm_key_writer
// Description : Initiator side of the SM key-write interface. Accepts a
//               freshly derived key as a stream of 16-bit words (valid/ready)
//               and replays each word as a one-cycle write_key strobe with an
//               incrementing key_idx. Word 0 is the most significant part of
//               the key. Signals completion (done), abort/timeout (error)
//               and holds busy while a transfer is in progress.
// Ports       : mclk, puc_rst         - clock, async active-high reset
//               start                 - begin a key transfer (ignored if busy)
//               abort                 - cancel the transfer in progress
//               kw_data/kw_valid      - key word stream from derivation engine
//               kw_ready              - word accepted this cycle (state decode)
//               write_key/key_in/key_idx - registered write strobe to SPM array
//               busy                  - transfer in progress
//               done / error          - one-cycle completion / failure pulses
// Revision    : 1.0 - initial release
// ============================================================================
module omsp_spm_key_writer
    import omsp_spm_key_writer_pkg::*;
#(
    parameter int unsigned SECURITY     = SPM_SECURITY,
    parameter int unsigned KEY_IDX_SIZE = 2,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                    mclk,
    input  logic                    puc_rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [15:0]             kw_data,
    input  logic                    kw_valid,
    output logic                    kw_ready,
    output logic                    write_key,
    output logic [15:0]             key_in,
    output logic [KEY_IDX_SIZE-1:0] key_idx,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam int unsigned       NW         = spm_nw(SECURITY);
    // One spare bit so the counter can represent NW without wrapping.
    localparam int unsigned       CW         = KEY_IDX_SIZE + 1;
    localparam logic [CW-1:0]     C_LAST_IDX = CW'(NW - 1);

    kw_state_e                state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     write_key_q, write_key_d;
    logic [15:0]              key_in_q, key_in_d;
    logic [KEY_IDX_SIZE-1:0]  key_idx_q, key_idx_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;

    logic                     w_to_clear;
    logic                     w_to_inc;
    logic                     w_to_enable;
    logic                     w_to_expire;

    omsp_spm_key_writer_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .mclk     (mclk),
        .puc_rst  (puc_rst),
        .clear_i  (w_to_clear),
        .inc_i    (w_to_inc),
        .enable_o (w_to_enable),
        .expire_o (w_to_expire)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_key_d = 1'b0;
        key_in_d    = key_in_q;
        key_idx_d   = key_idx_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        w_to_clear  = 1'b0;
        w_to_inc    = 1'b0;

        case (state_q)
            KW_IDLE: begin
                // abort carries no meaning here, so start always wins.
                if (start) begin
                    state_d    = KW_COLLECT;
                    cnt_d      = '0;
                    w_to_clear = 1'b1;
                end
            end

            KW_COLLECT: begin
                if (abort) begin
                    // A coincident handshake is dropped: no write follows.
                    state_d    = KW_IDLE;
                    error_d    = 1'b1;
                    w_to_clear = 1'b1;
                end else if (kw_valid) begin
                    write_key_d = 1'b1;
                    key_in_d    = kw_data;
                    key_idx_d   = cnt_q[KEY_IDX_SIZE-1:0];
                    cnt_d       = cnt_q + CW'(1);
                    w_to_clear  = 1'b1;
                    if (cnt_q == C_LAST_IDX) begin
                        state_d = KW_FLUSH;
                    end
                end else if (w_to_enable && w_to_expire) begin
                    // This idle cycle is the TIMEOUT-th one in a row.
                    state_d  = KW_IDLE;
                    error_d  = 1'b1;
                    w_to_inc = 1'b1;
                end else begin
                    w_to_inc = 1'b1;
                end
            end

            KW_FLUSH: begin
                // The final write_key is on the outputs during this cycle.
                state_d = KW_IDLE;
                if (abort) begin
                    error_d = 1'b1;
                end else begin
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = KW_IDLE;
            end
        endcase

        // Registered from the next state so busy drops with done/error.
        busy_d = (state_d != KW_IDLE);
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q     <= KW_IDLE;
            cnt_q       <= '0;
            write_key_q <= 1'b0;
            key_in_q    <= 16'h0000;
            key_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_key_q <= write_key_d;
            key_in_q    <= key_in_d;
            key_idx_q   <= key_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign kw_ready  = (state_q == KW_COLLECT);
    assign write_key = write_key_q;
    assign key_in    = key_in_q;
    assign key_idx   = key_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_omsp_spm_key_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_omsp_spm_key_writer
// Description : Self-checking bench for omsp_spm_key_writer (SECURITY=64,
//               TIMEOUT=5). A transaction-level reference model predicts all
//               outputs every cycle; directed scenarios add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_omsp_spm_key_writer;

    localparam int unsigned P_SECURITY = 64;
    localparam int unsigned P_IDX_W    = 2;
    localparam int unsigned P_TIMEOUT  = 5;
    localparam int          NWORDS     = P_SECURITY / 16;

    logic               mclk = 1'b0;
    logic               puc_rst = 1'b1;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [15:0]        kw_data = 16'h0;
    logic               kw_valid = 1'b0;
    logic               kw_ready;
    logic               write_key;
    logic [15:0]        key_in;
    logic [P_IDX_W-1:0] key_idx;
    logic               busy;
    logic               done;
    logic               error;

    omsp_spm_key_writer #(
        .SECURITY     (P_SECURITY),
        .KEY_IDX_SIZE (P_IDX_W),
        .TIMEOUT      (P_TIMEOUT)
    ) dut (
        .mclk      (mclk),
        .puc_rst   (puc_rst),
        .start     (start),
        .abort     (abort),
        .kw_data   (kw_data),
        .kw_valid  (kw_valid),
        .kw_ready  (kw_ready),
        .write_key (write_key),
        .key_in    (key_in),
        .key_idx   (key_idx),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 mclk = ~mclk;

    int checks   = 0;
    int failures = 0;
    int pcyc     = 0;

    always @(posedge mclk) pcyc <= pcyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, pcyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a transfer is "in flight" from start until either
    // all words have been taken and one closing cycle has passed, or it is
    // cut short by abort / TIMEOUT consecutive wordless cycles.
    // ------------------------------------------------------------------
    bit          m_xfer;
    int          m_words;
    int          m_idle;
    logic        m_wk, m_done, m_err;
    logic [15:0] m_key;
    int          m_idx;

    always @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            m_xfer = 0; m_words = 0; m_idle = 0;
            m_wk = 0; m_done = 0; m_err = 0; m_key = 16'h0; m_idx = 0;
        end else begin
            m_wk = 0; m_done = 0; m_err = 0;
            if (!m_xfer) begin
                if (start) begin
                    m_xfer = 1; m_words = 0; m_idle = 0;
                end
            end else if (m_words == NWORDS) begin
                m_xfer = 0;
                if (abort) m_err = 1; else m_done = 1;
            end else if (abort) begin
                m_xfer = 0; m_err = 1;
            end else if (kw_valid) begin
                m_wk = 1; m_key = kw_data; m_idx = m_words;
                m_words++; m_idle = 0;
            end else begin
                m_idle++;
                if (m_idle == P_TIMEOUT) begin
                    m_xfer = 0; m_err = 1;
                end
            end
        end
    end

    // Observed-event logs for the directed literal checks.
    int wq_idx[$];
    int wq_dat[$];
    int wq_cyc[$];
    int done_cnt = 0, done_cyc = -1, err_cnt = 0, err_cyc = -1;
    logic done_busy = 1'b1;

    always @(negedge mclk) begin
        if (!puc_rst) begin
            chk("write_key", write_key, m_wk);
            chk("key_in",    key_in,    m_key);
            chk("key_idx",   key_idx,   m_idx[P_IDX_W-1:0]);
            chk("busy",      busy,      m_xfer);
            chk("done",      done,      m_done);
            chk("error",     error,     m_err);
            chk("kw_ready",  kw_ready,  m_xfer && (m_words < NWORDS));
            if (write_key === 1'b1) begin
                wq_idx.push_back(int'(key_idx));
                wq_dat.push_back(int'(key_in));
                wq_cyc.push_back(pcyc);
            end
            if (done === 1'b1) begin
                done_cnt++; done_cyc = pcyc; done_busy = busy;
            end
            if (error === 1'b1) begin
                err_cnt++; err_cyc = pcyc;
            end
        end
    end

    // Drive one cycle's inputs at a falling edge and advance to the next.
    task automatic drive(input logic s, input logic a, input logic v, input logic [15:0] d);
        start = s; abort = a; kw_valid = v; kw_data = d;
        @(negedge mclk);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 16'h0);
    endtask

    logic [15:0] nom_words [4];
    logic [15:0] rst_words [4];
    logic        stall_v   [7];
    int          hs_cyc[$];
    int          base, dbase, ebase, s0, wptr;

    initial begin
        nom_words[0] = 16'hA1A1; nom_words[1] = 16'hB2B2;
        nom_words[2] = 16'hC3C3; nom_words[3] = 16'hD4D4;
        rst_words[0] = 16'h9001; rst_words[1] = 16'h9002;
        rst_words[2] = 16'h9003; rst_words[3] = 16'h9004;
        stall_v[0] = 1; stall_v[1] = 0; stall_v[2] = 0; stall_v[3] = 1;
        stall_v[4] = 0; stall_v[5] = 1; stall_v[6] = 1;

        // Reset state
        #12;
        chk("rst_write_key", write_key, 1'b0);
        chk("rst_key_in",    key_in,    16'h0);
        chk("rst_key_idx",   key_idx,   2'd0);
        chk("rst_busy",      busy,      1'b0);
        chk("rst_done_err",  {done, error}, 2'b00);
        chk("rst_kw_ready",  kw_ready,  1'b0);
        @(negedge mclk);
        @(negedge mclk);
        puc_rst = 1'b0;
        idle_n(2);

        // Nominal back-to-back transfer
        base = wq_idx.size(); dbase = done_cnt; ebase = err_cnt;
        drive(1, 0, 0, 16'h0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, nom_words[i]);
        idle_n(3);
        chk("nom_nwrites", wq_idx.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < wq_idx.size()) begin
                chk("nom_idx",  wq_idx[base+i], i);
                chk("nom_data", wq_dat[base+i], nom_words[i]);
                if (i > 0) chk("nom_consec", wq_cyc[base+i] - wq_cyc[base+i-1], 1);
            end
        end
        chk("nom_done_cnt", done_cnt - dbase, 1);
        if (wq_cyc.size() > 0) chk("nom_done_cyc", done_cyc, wq_cyc[wq_cyc.size()-1] + 1);
        chk("nom_busy_at_done", done_busy, 1'b0);
        chk("nom_no_err", err_cnt - ebase, 0);

        // Stalled source: 1-0-0-1-0-1-1
        base = wq_idx.size(); dbase = done_cnt;
        drive(1, 0, 0, 16'h0);
        wptr = 0;
        hs_cyc.delete();
        for (int i = 0; i < 7; i++) begin
            if (stall_v[i]) begin
                hs_cyc.push_back(pcyc + 1);
                drive(0, 0, 1, 16'h1111 * (wptr + 1));
                wptr++;
            end else begin
                drive(0, 0, 0, 16'h0);
            end
        end
        idle_n(3);
        chk("stall_nwrites", wq_idx.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < wq_idx.size()) begin
                chk("stall_idx", wq_idx[base+i], i);
                chk("stall_cyc", wq_cyc[base+i], hs_cyc[i]);
                chk("stall_data", wq_dat[base+i], 16'h1111 * (i + 1));
            end
        end
        chk("stall_done", done_cnt - dbase, 1);

        // Abort coincident with the third handshake
        base = wq_idx.size(); dbase = done_cnt; ebase = err_cnt;
        drive(1, 0, 0, 16'h0);
        drive(0, 0, 1, 16'h0101);
        drive(0, 0, 1, 16'h0202);
        drive(0, 1, 1, 16'h0303);
        chk("abort_kw_ready", kw_ready, 1'b0);
        chk("abort_error",    error,    1'b1);
        chk("abort_busy",     busy,     1'b0);
        idle_n(3);
        chk("abort_nwrites", wq_idx.size() - base, 2);
        if (wq_idx.size() >= base + 2) chk("abort_last_idx", wq_idx[base+1], 1);
        chk("abort_err_cnt", err_cnt - ebase, 1);
        chk("abort_no_done", done_cnt - dbase, 0);

        // Timeout after 5 wordless cycles
        base = wq_idx.size(); dbase = done_cnt; ebase = err_cnt;
        s0 = pcyc;
        drive(1, 0, 0, 16'h0);
        idle_n(9);
        chk("to_err_cnt", err_cnt - ebase, 1);
        chk("to_err_cyc", err_cyc, s0 + 6);
        chk("to_nwrites", wq_idx.size() - base, 0);
        chk("to_no_done", done_cnt - dbase, 0);
        drive(1, 0, 0, 16'h0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, nom_words[i]);
        idle_n(3);
        chk("to_retry_writes", wq_idx.size() - base, 4);
        chk("to_retry_done", done_cnt - dbase, 1);

        // kw_valid in IDLE, start repeated while busy
        base = wq_idx.size(); dbase = done_cnt;
        drive(0, 0, 1, 16'hEEEE);
        drive(0, 0, 1, 16'hEEEE);
        drive(0, 0, 1, 16'hEEEE);
        chk("idle_valid_nowrite", wq_idx.size() - base, 0);
        drive(1, 0, 1, 16'hEEEE);
        drive(0, 0, 1, 16'h1001);
        drive(1, 0, 1, 16'h1002);
        drive(1, 0, 1, 16'h1003);
        drive(0, 0, 1, 16'h1004);
        drive(1, 0, 0, 16'h0);
        idle_n(3);
        chk("restart_nwrites", wq_idx.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < wq_idx.size()) begin
                chk("restart_idx",  wq_idx[base+i], i);
                chk("restart_data", wq_dat[base+i], 16'h1001 + i);
            end
        end
        chk("restart_done", done_cnt - dbase, 1);

        // Reset in the middle of a transfer
        drive(1, 0, 0, 16'h0);
        drive(0, 0, 1, 16'h5555);
        chk("pre_rst_write", write_key, 1'b1);
        #2 puc_rst = 1'b1;
        #1;
        chk("mid_rst_write_key", write_key, 1'b0);
        chk("mid_rst_key_in",    key_in,    16'h0);
        chk("mid_rst_busy",      busy,      1'b0);
        chk("mid_rst_kw_ready",  kw_ready,  1'b0);
        start = 0; kw_valid = 0;
        @(negedge mclk);
        @(negedge mclk);
        puc_rst = 1'b0;
        base = wq_idx.size(); dbase = done_cnt; ebase = err_cnt;
        drive(0, 0, 0, 16'h0);
        drive(1, 0, 0, 16'h0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, rst_words[i]);
        idle_n(3);
        chk("post_rst_nwrites", wq_idx.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < wq_idx.size()) begin
                chk("post_rst_idx",  wq_idx[base+i], i);
                chk("post_rst_data", wq_dat[base+i], rst_words[i]);
            end
        end
        chk("post_rst_done", done_cnt - dbase, 1);
        chk("post_rst_no_err", err_cnt - ebase, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/omsp_spm_key_writer.md
Name: omsp_spm_key_writer

Overview:
- Initiator side of the SM key-write interface (write_key / key_in / key_idx) consumed by the SPM control array.
- Collects a freshly derived module key from the key-derivation engine as a stream of 16-bit words (valid/ready).
- Replays the words as single-cycle key-write strobes with incrementing index. Reports completion, abort and timeout to the execution unit, which holds the CPU while busy.

Parameters:
- SECURITY, 64, key width in bits; multiple of 16, at least 32.
- KEY_IDX_SIZE, 2, width of key_idx; equals clog2(SECURITY/16).
- TIMEOUT, 255, max idle cycles waiting for a word while busy; 8-bit counter; 0 disables the timeout.

Ports:
- mclk  input  1  core clock.
- puc_rst  input  1  asynchronous, active-high reset.
- start  input  1  pulse: begin writing a key for the SM just enabled.
- abort  input  1  cancel the transfer in progress.
- kw_data  input  16  key word from derivation engine.
- kw_valid  input  1  kw_data valid.
- kw_ready  output  1  writer accepts kw_data this cycle.
- write_key  output  1  one-cycle strobe to SPM array.
- key_in  output  16  key word accompanying write_key.
- key_idx  output  KEY_IDX_SIZE  word index accompanying write_key.
- busy  output  1  transfer in progress (IDLE excluded).
- done  output  1  one-cycle pulse: all SECURITY/16 words written.
- error  output  1  one-cycle pulse: abort or timeout terminated the transfer.

Behaviour:
- Reset: state IDLE, word counter 0, timeout counter 0.
- All outputs are registered except kw_ready (decoded from state).
- Reset values: write_key=0, key_in=16'h0, key_idx=0, busy=0, done=0, error=0.
- Let NW = SECURITY/16.
- IDLE:
  - kw_ready=0.
  - start=1 -> COLLECT; clear word counter and timeout counter.
  - kw_valid is ignored.
- COLLECT:
  - kw_ready=1.
  - Handshake (kw_valid & kw_ready) at edge N: cycle N+1 has write_key=1, key_in=kw_data, key_idx=counter. Then counter+1 and timeout counter cleared.
  - Back-to-back handshakes give one write per cycle.
  - Handshake on word NW-1 -> FLUSH.
  - No handshake: timeout counter+1.
- FLUSH:
  - kw_ready=0; the last write_key is visible this cycle.
  - Next state IDLE; done=1 for exactly one cycle, concurrent with the first IDLE cycle.
- write_key is 0 in every cycle not directly following a handshake. key_in and key_idx hold their last values when write_key=0.
- Word order: word k lands at key_idx k, with k=0 the most significant 16 bits of the key.
- Abort:
  - abort=1 in COLLECT or FLUSH -> IDLE next edge; error=1 one cycle; done not asserted.
  - Abort has priority over a coincident handshake: that word is dropped and no write_key is issued.
  - A write_key already registered (visible in the abort cycle) stands.
- Timeout: TIMEOUT!=0 and the timeout counter reaches TIMEOUT in COLLECT -> same as abort (IDLE, error pulse).
- start while busy is ignored. start and abort together in IDLE: start wins, since abort has no meaning in IDLE.
- The counter is KEY_IDX_SIZE+1 bits wide, so there is no wrap inside a transfer. The counter never exceeds NW.
- Reset mid-transfer: immediate return to IDLE with all outputs at reset values; no done or error pulse.
- busy = (state != IDLE); it falls in the same cycle done or error rises.

Decomposition:
- Shared package/defines:
  - state encoding localparams (IDLE=2'd0, COLLECT=2'd1, FLUSH=2'd2);
  - NW derivation;
  - the existing SECURITY define.
- One natural sub-module: omsp_spm_key_writer_timeout, a loadable saturating idle counter with clear, enable and expire outputs.
- The FSM, data register and index counter stay in the top level.

Test Plan:
- Nominal, SECURITY=64: start; words 16'hA1A1, B2B2, C3C3, D4D4 presented back-to-back -> write_key high 4 consecutive cycles with key_idx 0..3 and matching key_in; done one cycle after the last write; busy drops with done.
- Stalled source: kw_valid toggles 1-0-0-1-0-1-1 -> exactly 4 write_key strobes, each one cycle after its handshake, key_idx strictly increasing; no write in gap cycles.
- Abort after 2 words, coincident with handshake on word 3 -> writes at idx 0,1 only; error pulse; no done; kw_ready=0 next cycle.
- Timeout, TIMEOUT=5: start, no kw_valid -> error after 5 idle cycles; zero write_key strobes; later start completes normally.
- start repeated while busy, and kw_valid high in IDLE -> no extra writes, no restart; counter unaffected.
- puc_rst asserted after 1 word -> all outputs 0 immediately; after release, a start with 4 words writes idx 0..3 from scratch.
